// File: rtl/register_file_param.sv
// register_file_param
//
// Parametrised register file: one decoded write port, two registered read
// ports with optional write-first forwarding, and a clear sequencer that
// zeroes one entry per cycle after a clr_req.
//
// Ports:
//   clk            single clock, all state on the rising edge
//   reset          synchronous, active-high
//   we/wAddr/wData write port
//   rAddr0/rAddr1  read addresses; rData0/rData1 valid one cycle later
//   clr_req        start a clear sweep (ignored while one is running)
//   busy           clear sweep in progress (writes are masked)
//   wEn            one-hot write strobe applied this cycle (combinational)

module register_file_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter bit          BYPASS     = 1'b1,
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wAddr,
    input  logic [DATA_WIDTH-1:0] wData,
    input  logic [ADDR_WIDTH-1:0] rAddr0,
    input  logic [ADDR_WIDTH-1:0] rAddr1,
    input  logic                  clr_req,
    output logic [DATA_WIDTH-1:0] rData0,
    output logic [DATA_WIDTH-1:0] rData1,
    output logic                  busy,
    output logic [DEPTH-1:0]      wEn
);

    typedef enum logic {StIdle, StClear} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // FSM next state: clr_req is only looked at in idle, so it can never
    // restart or stretch a sweep already in progress.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            StClear: begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = 1'b0;
        unique case (state_q)
            StIdle:  busy = 1'b0;
            StClear: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Write decode, masked while the sweep owns the array
    always_comb begin
        wEn = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            wEn[i] = we && !busy && (wAddr == ADDR_WIDTH'(i));
        end
    end

    // Post-edge array contents; also the forwarding source for bypass reads
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
            if (wEn[i]) begin
                mem_d[i] = wData;
            end
            if (busy && (ptr_q == ADDR_WIDTH'(i))) begin
                mem_d[i] = '0;
            end
        end
    end

    // Bypass reads the value being committed this edge, otherwise the old one
    always_comb begin
        rdata0_d = BYPASS ? mem_d[rAddr0] : mem_q[rAddr0];
        rdata1_d = BYPASS ? mem_d[rAddr1] : mem_q[rAddr1];
    end

    // Storage and read registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            mem_q    <= mem_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign rData0 = rdata0_q;
    assign rData1 = rdata1_q;

endmodule
